// File: rtl/aes256_out_serializer.sv
// Block FIFO behind the AES-256 encryptor; drains each block as W-bit words, MS word first.
// Optional macro AES_OUT_OVF_CNT_EN builds a saturating dropped-block counter on ovf_count.
module aes256_out_serializer #(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N-1:0][7:0]   encData,
  input  logic                done,
  output logic [W-1:0]        dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                dout_last,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic [7:0]          ovf_count
);

  localparam int unsigned BW  = N * 8;
  localparam int unsigned WPB = BW / W;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned IW  = (WPB > 1) ? $clog2(WPB) : 1;

  logic [BW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_word_idx;
  logic          r_overflow;

  logic [BW-1:0] w_head;
  logic [BW-1:0] w_shifted;
  logic          w_full;
  logic          w_empty;
  logic          w_valid;
  logic          w_word_last;
  logic          w_xfer;
  logic          w_pop;
  logic          w_write;
  logic          w_drop;

  always_comb begin
    w_full      = (r_count == CW'(DEPTH));
    w_empty     = (r_count == '0);
    w_valid     = !w_empty;
    w_word_last = (r_word_idx == IW'(WPB - 1));
    w_xfer      = w_valid && dout_ready;
    w_pop       = w_xfer && w_word_last;
    // A pop frees a slot in the same cycle, so a done that lands then is still accepted.
    w_write     = done && (!w_full || w_pop);
    w_drop      = done && w_full && !w_pop;
  end

  always_comb begin
    w_head    = r_mem[r_rd_ptr];
    w_shifted = w_head << (W * r_word_idx);
    dout      = '0;
    if (w_valid) begin
      dout = w_shifted[BW-1 -: W];
    end
  end

  assign dout_valid = w_valid;
  assign dout_last  = w_valid && w_word_last;
  assign full       = w_full;
  assign empty      = w_empty;
  assign overflow   = r_overflow;

  always_ff @(posedge clk) begin
    if (resetn && w_write) begin
      r_mem[r_wr_ptr] <= encData;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_word_idx <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_word_idx <= w_word_last ? '0 : r_word_idx + IW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      end
      if (w_write) begin
        r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_write && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_write) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef AES_OUT_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != 8'hff)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign ovf_count = r_ovf_cnt;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_aes256_out_serializer.sv
// Directed bench for aes256_out_serializer at default parameters (N=16, DEPTH=2, W=32).
// Expected ovf_count follows AES_OUT_OVF_CNT_EN; the saturation case runs only when it is defined.
module tb_aes256_out_serializer;

  logic              clk;
  logic              resetn;
  logic [15:0][7:0]  encData;
  logic              done;
  logic [31:0]       dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic              full;
  logic              empty;
  logic              overflow;
  logic [7:0]        ovf_count;

  int unsigned n_checks;
  int unsigned n_fail;

  localparam logic [127:0] BlkT = 128'hcc6f84800354f24a045f32ee85ff2d4b;
  localparam logic [127:0] BlkA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BlkB = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] BlkC = 128'hdeadbeefcafef00d0123456789abcdef;

`ifdef AES_OUT_OVF_CNT_EN
  localparam logic [7:0] OvfOne = 8'd1;
`else
  localparam logic [7:0] OvfOne = 8'd0;
`endif

  aes256_out_serializer dut (
    .clk        (clk),
    .resetn     (resetn),
    .encData    (encData),
    .done       (done),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .ovf_count  (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    done   = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic push(input logic [127:0] blk);
    encData = blk;
    done    = 1'b1;
    step();
    done    = 1'b0;
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] blk, input int k);
    logic [127:0] s;
    s = blk << (32 * k);
    return s[127:96];
  endfunction

  // Drain one block at ready=1, checking each word and the last flag.
  task automatic drain_block(input string tag, input logic [127:0] blk);
    for (int k = 0; k < 4; k++) begin
      check_eq({tag, "_valid"}, 128'(dout_valid), 128'(1'b1));
      check_eq({tag, "_word"}, 128'(dout), 128'(word_of(blk, k)));
      check_eq({tag, "_last"}, 128'(dout_last), 128'(k == 3));
      step();
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    resetn     = 1'b0;
    done       = 1'b0;
    dout_ready = 1'b0;
    encData    = '0;
    step();
    do_reset();

    check_eq("rst_valid", 128'(dout_valid), 128'(1'b0));
    check_eq("rst_last", 128'(dout_last), 128'(1'b0));
    check_eq("rst_empty", 128'(empty), 128'(1'b1));
    check_eq("rst_full", 128'(full), 128'(1'b0));
    check_eq("rst_ovf", 128'(overflow), 128'(1'b0));
    check_eq("rst_ovfcnt", 128'(ovf_count), 128'(8'd0));
    check_eq("rst_dout", 128'(dout), 128'(32'd0));

    // Single block, ready held high: words appear at t+1..t+4.
    dout_ready = 1'b1;
    push(BlkT);
    check_eq("single_w0", 128'(dout), 128'(32'hcc6f8480));
    step();
    check_eq("single_w1", 128'(dout), 128'(32'h0354f24a));
    step();
    check_eq("single_w2", 128'(dout), 128'(32'h045f32ee));
    check_eq("single_nolast", 128'(dout_last), 128'(1'b0));
    step();
    check_eq("single_w3", 128'(dout), 128'(32'h85ff2d4b));
    check_eq("single_last", 128'(dout_last), 128'(1'b1));
    step();
    check_eq("single_empty", 128'(empty), 128'(1'b1));
    check_eq("single_novalid", 128'(dout_valid), 128'(1'b0));

    // Backpressure: word 0 holds while stalled.
    dout_ready = 1'b0;
    push(BlkT);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_hold", 128'(dout), 128'(32'hcc6f8480));
      check_eq("bp_valid", 128'(dout_valid), 128'(1'b1));
      step();
    end
    dout_ready = 1'b1;
    drain_block("bp", BlkT);
    check_eq("bp_empty", 128'(empty), 128'(1'b1));

    // Fill and drop: C arrives with the FIFO full.
    dout_ready = 1'b0;
    push(BlkA);
    check_eq("fill_notfull", 128'(full), 128'(1'b0));
    push(BlkB);
    check_eq("fill_full", 128'(full), 128'(1'b1));
    check_eq("fill_noovf", 128'(overflow), 128'(1'b0));
    push(BlkC);
    check_eq("drop_ovf", 128'(overflow), 128'(1'b1));
    check_eq("drop_ovfcnt", 128'(ovf_count), 128'(OvfOne));
    check_eq("drop_full", 128'(full), 128'(1'b1));
    dout_ready = 1'b1;
    drain_block("dropA", BlkA);
    drain_block("dropB", BlkB);
    check_eq("drop_empty", 128'(empty), 128'(1'b1));
    check_eq("drop_sticky", 128'(overflow), 128'(1'b1));

    // Write coincident with the pop of a full FIFO's head block.
    do_reset();
    dout_ready = 1'b0;
    push(BlkA);
    push(BlkB);
    dout_ready = 1'b1;
    step();
    step();
    step();
    check_eq("sim_last", 128'(dout_last), 128'(1'b1));
    push(BlkC);
    check_eq("sim_full", 128'(full), 128'(1'b1));
    check_eq("sim_noovf", 128'(overflow), 128'(1'b0));
    drain_block("simB", BlkB);
    drain_block("simC", BlkC);
    check_eq("sim_empty", 128'(empty), 128'(1'b1));

    // Reset mid-drain discards everything and clears the sticky flag.
    dout_ready = 1'b0;
    push(BlkA);
    push(BlkB);
    push(BlkC);
    check_eq("mid_ovf_set", 128'(overflow), 128'(1'b1));
    dout_ready = 1'b1;
    step();
    step();
    check_eq("mid_w2", 128'(dout), 128'(word_of(BlkA, 2)));
    do_reset();
    check_eq("mid_valid", 128'(dout_valid), 128'(1'b0));
    check_eq("mid_empty", 128'(empty), 128'(1'b1));
    check_eq("mid_ovf", 128'(overflow), 128'(1'b0));
    check_eq("mid_ovfcnt", 128'(ovf_count), 128'(8'd0));
    push(BlkB);
    drain_block("midB", BlkB);
    check_eq("mid_after_empty", 128'(empty), 128'(1'b1));

`ifdef AES_OUT_OVF_CNT_EN
    // 260 drops saturate the counter at 255.
    do_reset();
    dout_ready = 1'b0;
    push(BlkA);
    push(BlkB);
    encData = BlkC;
    done    = 1'b1;
    for (int i = 0; i < 254; i++) step();
    check_eq("sat_254", 128'(ovf_count), 128'(8'd254));
    for (int i = 0; i < 6; i++) step();
    done = 1'b0;
    check_eq("sat_255", 128'(ovf_count), 128'(8'd255));
    check_eq("sat_ovf", 128'(overflow), 128'(1'b1));
    dout_ready = 1'b1;
    drain_block("satA", BlkA);
    drain_block("satB", BlkB);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes256_out_serializer.md
Name: aes256_out_serializer

Overview:
- Downstream stage of the AES-256 encryptor.
- Captures each 128-bit encData block on its done pulse into a small block FIFO.
- Drains the FIFO as 32-bit words over a valid/ready stream, most significant word first, to the bus/output interface.
- Absorbs backpressure so the encryptor never stalls; a block that arrives when the FIFO is full is dropped and flagged.

Parameters:
- N, 16, bytes per block; must match the encryptor's block width.
- DEPTH, 2, block slots in the FIFO; power of 2, at least 1.
- W, 32, output word width in bits; N*8 must be a multiple of W. WPB = N*8/W is the number of words per block (4 at defaults).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous reset, active-low.
- encData  in  [N-1:0][7:0]  ciphertext block from the encryptor.
- done  in  1  one-cycle pulse; encData is valid in the same cycle.
- dout  out  W  current output word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  consumer accepts dout in this cycle.
- dout_last  out  1  dout is the final word of its block.
- full  out  1  all DEPTH slots occupied.
- empty  out  1  no slots occupied.
- overflow  out  1  sticky; at least one block has been dropped.
- ovf_count  out  8  count of dropped blocks (see Optional Feature).

Behaviour:
- Reset: applied when resetn=0 at a clk edge. Clears wr_ptr, rd_ptr, count, word_idx, overflow and ovf_count to 0. Slot contents need not be cleared.
- Outputs after reset: dout_valid=0, dout_last=0, empty=1, full=0, overflow=0, ovf_count=0, dout=0.
- Reset mid-drain: all buffered blocks are discarded. dout_valid=0 on the first cycle after the reset edge.
- Storage: DEPTH x (N*8)-bit slots. count is clog2(DEPTH)+1 bits wide.
- Status flags: full = (count==DEPTH); empty = (count==0).
- Word order: word k of the head slot is bits [N*8-1-W*k -: W], so k=0 is encData[N-1]..encData[N-4]. dout is combinational from the head slot and word_idx. dout=0 when empty.
- Handshake outputs: dout_valid = !empty; dout_last = dout_valid && (word_idx==WPB-1).
- Transfer: a word is transferred when dout_valid && dout_ready.
  - On a transfer, word_idx increments.
  - If word_idx==WPB-1 (pop): word_idx returns to 0, rd_ptr advances modulo DEPTH, and count decrements.
  - dout holds its value while dout_valid && !dout_ready.
- Write: when done && (!full || pop), encData is stored at wr_ptr, wr_ptr advances modulo DEPTH, and count increments.
  - A write and a pop in the same cycle leave count unchanged. A done that arrives in the cycle the last word of a full FIFO drains is accepted.
- Drop: when done && full && !pop, the block is discarded and overflow is set to 1. overflow clears only on reset.
- Latency: done in cycle t into an empty FIFO gives dout_valid=1 with word 0 in cycle t+1.
- Throughput: with dout_ready held at 1, one word per cycle and WPB cycles per block. Back-to-back blocks produce no bubble.
- done while resetn=0 is ignored.
- Pointers wrap modulo DEPTH. No underflow is possible because pops require dout_valid.

Optional Feature:
- Macro AES_OUT_OVF_CNT_EN.
- Defined: ovf_count increments by 1 on every dropped block and saturates at 255. Reset sets it to 0.
- Not defined: ovf_count is tied to 0 and no counter register is built. The overflow flag behaves identically in both builds.

Test Plan:
- Single block: reset, then done with encData=128'hcc6f84800354f24a045f32ee85ff2d4b and dout_ready=1. Required: cycles t+1..t+4 give dout=cc6f8480, 0354f24a, 045f32ee, 85ff2d4b; dout_last only on 85ff2d4b; empty=1 afterwards.
- Backpressure: same block with dout_ready=0 for 5 cycles, then 1. Required: dout stays cc6f8480 with dout_valid=1 while stalled; the full 4-word sequence follows with no loss or duplication.
- Fill and drop: DEPTH=2, dout_ready=0, three done pulses with blocks A, B, C. Required: full=1 after B; C dropped; overflow=1; ovf_count=1 if AES_OUT_OVF_CNT_EN is defined, 0 otherwise. Draining yields A then B only.
- Simultaneous pop and write: FIFO full, done asserted in the cycle the last word of the head block is accepted. Required: block accepted, count stays 2, no overflow.
- Reset mid-drain: after 2 words of a block, drive resetn=0 for one edge. Required: dout_valid=0, empty=1, overflow=0 on the next cycle; a new block then drains starting at word 0.
- Saturation (macro defined): 260 drops while full. Required: ovf_count=255 and no wrap.
